// File: rtl/ping_scheduler.sv
// Ping burst controller: periodic tx strobes, per-slot echo first/last timestamping,
// accumulated result via valid/ready. Optional echo blanking under `PING_BLANK_EN.
module ping_scheduler #(
  parameter int PERIOD_W  = 11,
  parameter int NPING_W   = 4,
  parameter int ACC_W     = 16,
  parameter int BLANK_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [NPING_W-1:0] n_pings,
  input  logic               rx_stb,
  output logic               tx_stb,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_first,
  output logic [ACC_W-1:0]   res_last,
  output logic [NPING_W-1:0] res_hits,
  output logic [NPING_W-1:0] res_miss
);

  typedef enum logic [1:0] {IDLE, PING, LISTEN, REPORT} state_t;

  state_t              state_reg, state_next;
  logic [PERIOD_W-1:0] offset_reg;
  logic [PERIOD_W-1:0] first_reg;
  logic [PERIOD_W-1:0] last_reg;
  logic                hit_reg;
  logic [NPING_W-1:0]  left_reg;
  logic [ACC_W-1:0]    first_acc_reg;
  logic [ACC_W-1:0]    last_acc_reg;
  logic [NPING_W-1:0]  hits_reg;
  logic [NPING_W-1:0]  miss_reg;
  logic                tx_reg;
  logic                busy_reg;
  logic                valid_reg;

  logic                in_slot;
  logic                slot_end;
  logic                stb_cnt;
  logic                accept;
  logic                slot_hit;
  logic [PERIOD_W-1:0] slot_first;
  logic [PERIOD_W-1:0] slot_last;
  logic [ACC_W:0]      first_sum;
  logic [ACC_W:0]      last_sum;

  assign in_slot  = (state_reg == PING) || (state_reg == LISTEN);
  assign slot_end = (state_reg == LISTEN) && (offset_reg == {PERIOD_W{1'b1}});
  assign accept   = (state_reg == IDLE) && start && !abort;

`ifdef PING_BLANK_EN
  localparam logic [PERIOD_W:0] BLANK_END = BLANK_CYC[PERIOD_W:0];
  assign stb_cnt = in_slot && rx_stb && ({1'b0, offset_reg} >= BLANK_END);
`else
  assign stb_cnt = in_slot && rx_stb;
`endif

  // Slot state including the current cycle's strobe, so the final offset is not lost at close.
  assign slot_hit   = hit_reg || stb_cnt;
  assign slot_first = hit_reg ? first_reg : offset_reg;
  assign slot_last  = stb_cnt ? offset_reg : last_reg;
  assign first_sum  = {1'b0, first_acc_reg} + (ACC_W+1)'(slot_first);
  assign last_sum   = {1'b0, last_acc_reg} + (ACC_W+1)'(slot_last);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start && !abort) state_next = PING;
      PING:    state_next = LISTEN;
      LISTEN:  if (slot_end) state_next = (left_reg == NPING_W'(1)) ? REPORT : PING;
      REPORT:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && (state_reg != IDLE)) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      offset_reg    <= '0;
      first_reg     <= '0;
      last_reg      <= '0;
      hit_reg       <= 1'b0;
      left_reg      <= '0;
      first_acc_reg <= '0;
      last_acc_reg  <= '0;
      hits_reg      <= '0;
      miss_reg      <= '0;
      tx_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      // Outputs follow the next state so they line up with the state they describe.
      tx_reg     <= (state_next == PING);
      busy_reg   <= (state_next != IDLE);
      valid_reg  <= (state_next == REPORT);
      offset_reg <= in_slot ? offset_reg + PERIOD_W'(1) : '0;

      if (accept) begin
        left_reg      <= (n_pings == '0) ? NPING_W'(1) : n_pings;
        hit_reg       <= 1'b0;
        first_reg     <= '0;
        last_reg      <= '0;
        first_acc_reg <= '0;
        last_acc_reg  <= '0;
        hits_reg      <= '0;
        miss_reg      <= '0;
      end else if (in_slot) begin
        if (slot_end) begin
          hit_reg  <= 1'b0;
          left_reg <= left_reg - NPING_W'(1);
          if (slot_hit) begin
            first_acc_reg <= first_sum[ACC_W] ? {ACC_W{1'b1}} : first_sum[ACC_W-1:0];
            last_acc_reg  <= last_sum[ACC_W] ? {ACC_W{1'b1}} : last_sum[ACC_W-1:0];
            hits_reg      <= hits_reg + NPING_W'(1);
          end else begin
            miss_reg <= miss_reg + NPING_W'(1);
          end
        end else begin
          hit_reg   <= slot_hit;
          first_reg <= slot_first;
          last_reg  <= slot_last;
        end
      end
    end
  end

  assign tx_stb    = tx_reg;
  assign busy      = busy_reg;
  assign res_valid = valid_reg;
  assign res_first = first_acc_reg;
  assign res_last  = last_acc_reg;
  assign res_hits  = hits_reg;
  assign res_miss  = miss_reg;

endmodule

// File: tb/tb_ping_scheduler.sv
// Self-checking bench for ping_scheduler: directed scenarios plus randomized bursts
// checked against a per-slot min/max model of the echo strobes.
module tb_ping_scheduler;
  localparam int SLOT  = 2048;
  localparam int BLANK = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  n_pings = 4'd0;
  logic        rx_stb = 1'b0;
  logic        tx_stb;
  logic        busy;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_first;
  logic [15:0] res_last;
  logic [3:0]  res_hits;
  logic [3:0]  res_miss;

  int vectors = 0;
  int miscompares = 0;
  bit stb_map [4][SLOT];

  ping_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_pings(n_pings),
    .rx_stb(rx_stb), .tx_stb(tx_stb), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_first(res_first), .res_last(res_last),
    .res_hits(res_hits), .res_miss(res_miss)
  );

  always #5 clk = ~clk;

  function automatic bit counted(input int off);
`ifdef PING_BLANK_EN
    return off >= BLANK;
`else
    return 1'b1;
`endif
  endfunction

  task automatic clear_map();
    for (int s = 0; s < 4; s++)
      for (int o = 0; o < SLOT; o++) stb_map[s][o] = 1'b0;
  endtask

  // Reference: per slot, earliest and latest counted strobe; sums saturate at 16 bits.
  task automatic model(input int neff, output int ef, output int el, output int eh, output int em);
    ef = 0; el = 0; eh = 0; em = 0;
    for (int s = 0; s < neff; s++) begin
      int f = -1;
      int l = -1;
      for (int o = 0; o < SLOT; o++)
        if (stb_map[s][o] && counted(o)) begin
          if (f < 0) f = o;
          l = o;
        end
      if (f >= 0) begin
        ef = (ef + f > 65535) ? 65535 : ef + f;
        el = (el + l > 65535) ? 65535 : el + l;
        eh++;
      end else em++;
    end
  endtask

  task automatic run_burst(input string name, input int n, input int ready_wait,
                           output int gf, output int gl, output int gh, output int gm);
    int neff, ef, el, eh, em;
    int tx_bad = 0, busy_bad = 0, hold_bad = 0, idle_bad = 0;
    neff = (n == 0) ? 1 : n;
    model(neff, ef, el, eh, em);
    @(posedge clk); #1; start = 1'b1; n_pings = 4'(n);
    @(posedge clk); #1; start = 1'b0;
    for (int cyc = 1; cyc <= neff * SLOT; cyc++) begin
      rx_stb = stb_map[(cyc - 1) / SLOT][(cyc - 1) % SLOT];
      @(negedge clk);
      if (tx_stb !== (((cyc - 1) % SLOT) == 0)) tx_bad++;
      if (busy !== 1'b1 || res_valid !== 1'b0) busy_bad++;
      @(posedge clk); #1;
    end
    rx_stb = 1'b0;
    @(negedge clk);
    gf = int'(res_first); gl = int'(res_last); gh = int'(res_hits); gm = int'(res_miss);
    vectors++; if (tx_bad !== 0) begin miscompares++; $display("FAIL %s tx_stb timing: %0d bad cycles, required 0", name, tx_bad); end
    vectors++; if (busy_bad !== 0) begin miscompares++; $display("FAIL %s busy/valid in burst: %0d bad cycles, required 0", name, busy_bad); end
    vectors++; if (res_valid !== 1'b1 || tx_stb !== 1'b0) begin miscompares++; $display("FAIL %s valid at N*slot+1: valid=%b tx=%b, required 1/0", name, res_valid, tx_stb); end
    vectors++; if (gf !== ef) begin miscompares++; $display("FAIL %s res_first: got %0d required %0d", name, gf, ef); end
    vectors++; if (gl !== el) begin miscompares++; $display("FAIL %s res_last: got %0d required %0d", name, gl, el); end
    vectors++; if (gh !== eh || gm !== em) begin miscompares++; $display("FAIL %s hits/miss: got %0d/%0d required %0d/%0d", name, gh, gm, eh, em); end
    for (int i = 0; i < ready_wait; i++) begin
      @(posedge clk); #1;
      start = (i == ready_wait / 2); n_pings = 4'd3;
      @(negedge clk);
      if (res_valid !== 1'b1 || busy !== 1'b1 || tx_stb !== 1'b0 || int'(res_first) != ef ||
          int'(res_last) != el || int'(res_hits) != eh || int'(res_miss) != em) hold_bad++;
    end
    @(posedge clk); #1; start = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL %s release: busy=%b valid=%b, required 0/0", name, busy, res_valid); end
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_stb !== 1'b0) idle_bad++;
    end
    vectors++; if (hold_bad !== 0 || idle_bad !== 0) begin miscompares++; $display("FAIL %s hold/idle: %0d/%0d bad cycles, required 0/0", name, hold_bad, idle_bad); end
    $display("burst %s n=%0d: first=%0d last=%0d hits=%0d miss=%0d", name, n, gf, gl, gh, gm);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({tx_stb, busy, res_valid, res_first, res_last, res_hits, res_miss} !== '0) begin
      miscompares++; $display("FAIL reset outputs: got %h required 0",
        {tx_stb, busy, res_valid, res_first, res_last, res_hits, res_miss});
    end
    @(posedge clk); #1; rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_two_pings();
    int gf, gl, gh, gm;
    clear_map();
    for (int s = 0; s < 2; s++) begin stb_map[s][100] = 1'b1; stb_map[s][300] = 1'b1; end
    run_burst("two_pings", 2, 50, gf, gl, gh, gm);
    vectors++;
    if (gf != 200 || gl != 600 || gh != 2 || gm != 0) begin
      miscompares++; $display("FAIL two_pings const: got %0d/%0d/%0d/%0d required 200/600/2/0", gf, gl, gh, gm);
    end
  endtask

  task automatic test_miss_slot();
    int gf, gl, gh, gm;
    clear_map();
    stb_map[0][50] = 1'b1; stb_map[2][50] = 1'b1;
    run_burst("miss_slot", 3, 0, gf, gl, gh, gm);
    vectors++;
    if (gf != 100 || gl != 100 || gh != 2 || gm != 1) begin
      miscompares++; $display("FAIL miss_slot const: got %0d/%0d/%0d/%0d required 100/100/2/1", gf, gl, gh, gm);
    end
  endtask

  task automatic test_blank();
    int gf, gl, gh, gm, xf;
    clear_map();
    stb_map[0][10] = 1'b1; stb_map[0][500] = 1'b1;
`ifdef PING_BLANK_EN
    xf = 500;
`else
    xf = 10;
`endif
    run_burst("blank", 1, 3, gf, gl, gh, gm);
    vectors++;
    if (gf != xf || gl != 500) begin
      miscompares++; $display("FAIL blank const: got %0d/%0d required %0d/500", gf, gl, xf);
    end
  endtask

  task automatic test_abort();
    int bad = 0;
    @(posedge clk); #1; start = 1'b1; n_pings = 4'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (700) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx_stb !== 1'b0 || res_valid !== 1'b0) begin
      miscompares++; $display("FAIL abort next cycle: busy=%b tx=%b valid=%b, required 0/0/0", busy, tx_stb, res_valid);
    end
    repeat (4 * SLOT) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_stb !== 1'b0 || res_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL abort quiet: %0d bad cycles, required 0", bad); end
    // start and abort together in IDLE: abort wins
    @(posedge clk); #1; start = 1'b1; abort = 1'b1; n_pings = 4'd1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx_stb !== 1'b0) begin
      miscompares++; $display("FAIL start_abort idle: busy=%b tx=%b, required 0/0", busy, tx_stb);
    end
    $display("abort checked: %0d bad quiet cycles", bad);
  endtask

  task automatic test_reset_mid();
    int gf, gl, gh, gm;
    @(posedge clk); #1; start = 1'b1; n_pings = 4'd3;
    @(posedge clk); #1; start = 1'b0;
    for (int cyc = 1; cyc <= SLOT + 301; cyc++) begin
      rx_stb = (cyc == 101);
      @(posedge clk); #1;
    end
    rx_stb = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({tx_stb, busy, res_valid, res_first, res_last, res_hits, res_miss} !== '0) begin
      miscompares++; $display("FAIL reset_mid outputs: got %h required 0",
        {tx_stb, busy, res_valid, res_first, res_last, res_hits, res_miss});
    end
    clear_map();
    stb_map[0][$urandom_range(0, SLOT - 1)] = 1'b1;
    run_burst("after_reset_n0", 0, 2, gf, gl, gh, gm);
    vectors++;
    if (gh + gm != 1) begin miscompares++; $display("FAIL n0 slots: got %0d required 1", gh + gm); end
  endtask

  task automatic test_random();
    int gf, gl, gh, gm, n, k;
    for (int t = 0; t < 4; t++) begin
      clear_map();
      n = $urandom_range(0, 3);
      for (int s = 0; s < 4; s++) begin
        k = $urandom_range(0, 4);
        for (int j = 0; j < k; j++) stb_map[s][$urandom_range(0, SLOT - 1)] = 1'b1;
        stb_map[s][0] = 1'($urandom_range(0, 1));
        stb_map[s][SLOT - 1] = 1'($urandom_range(0, 1));
        stb_map[s][$urandom_range(0, BLANK - 1)] = 1'($urandom_range(0, 1));
      end
      run_burst($sformatf("random%0d", t), n, $urandom_range(0, 10), gf, gl, gh, gm);
    end
  endtask

  initial begin
    test_reset();
    test_two_pings();
    test_miss_slot();
    test_blank();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ping_scheduler.md
# ping_scheduler

Burst controller for the phase-ping measurement path. It issues a train of transmit strobes on a fixed power-of-two period and time-stamps echo strobes from the digitizer against each ping. It accumulates first-arrival and last-arrival offsets over a programmable number of pings, then presents one result record through a valid/ready handshake to the hex-dump/UART reporter. It replaces ad-hoc sequencing logic in the top level: the UART command strobe drives `start`, `tx_stb` drives the transmitter, and `rx_stb` comes from the receive path.

## Interface
- `PERIOD_W`, default 11: ping slot length is 2^PERIOD_W clk cycles.
- `NPING_W`, default 4: width of ping count and of the hit/miss counters.
- `ACC_W`, default 16: width of the first/last offset accumulators.
- `BLANK_CYC`, default 64: blanking window length in cycles; used only with `PING_BLANK_EN`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle burst request. Ignored while `busy`.
- `abort` in 1: cancels the burst. No result is produced.
- `n_pings` in NPING_W: pings per burst, sampled on accepted `start`. A value of 0 is treated as 1.
- `rx_stb` in 1: echo strobe, one per detected edge, synchronous to clk.
- `tx_stb` out 1: one-cycle transmit trigger.
- `busy` out 1: high from accepted `start` until the result is accepted or the burst is aborted.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_first` out ACC_W: sum of first-hit offsets over slots that had hits.
- `res_last` out ACC_W: sum of last-hit offsets over slots that had hits.
- `res_hits` out NPING_W: number of slots with at least one counted strobe.
- `res_miss` out NPING_W: number of slots with no counted strobe.

## Operation
- States: IDLE, PING, LISTEN, REPORT.
- IDLE: a `start` with `abort` low latches `n_pings`, clears the accumulators and counters, and moves to PING. `busy` goes high the next cycle.
- PING: lasts one cycle, in which `tx_stb`=1. The offset counter is 0 in this cycle.
- LISTEN: covers offsets 1 to 2^PERIOD_W−1.
  - At offset 2^PERIOD_W−1, the next state is PING if slots remain, otherwise REPORT.
- Per slot:
  - The first counted `rx_stb` latches `first`=offset.
  - Every counted `rx_stb` latches `last`=offset.
  - Strobes at offset 0 (the PING cycle) count.
- Slot close happens in the cycle after offset 2^PERIOD_W−1.
  - If the slot had a hit: `res_first`+=first, `res_last`+=last, `res_hits`+=1.
  - Otherwise: `res_miss`+=1.
  - Accumulators saturate at all-ones. Counters cannot overflow because `n_pings` is below 2^NPING_W.
- REPORT: `res_valid`=1 with all `res_*` held stable. On `res_valid`&&`res_ready` the block returns to IDLE and `busy`=0 the next cycle.
- `abort` in any non-IDLE state moves to IDLE the next cycle.
  - `tx_stb`, `res_valid` and `busy` drop.
  - `res_*` values are don't-care.
- Simultaneous `start`+`abort` in IDLE: abort wins, and the block stays IDLE.
- `start` during `busy` is ignored, including in REPORT.

## Timing
- Reset values: `tx_stb`=0, `busy`=0, `res_valid`=0, `res_first`=0, `res_last`=0, `res_hits`=0, `res_miss`=0. The state is IDLE.
- `start` at cycle S:
  - First `tx_stb` at S+1.
  - Subsequent `tx_stb` at S+1+k·2^PERIOD_W.
- `res_valid` rises at S+1+N·2^PERIOD_W, where N is the effective ping count.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset mid-burst returns all outputs to their reset values on the next clock edge.

## Configuration
- `PING_BLANK_EN` defined: `rx_stb` at offsets 0 to BLANK_CYC−1 is ignored. This rejects direct TX→RX crosstalk. Such strobes neither set `first`/`last` nor mark the slot as hit.
- `PING_BLANK_EN` undefined: every offset counts, and `BLANK_CYC` has no effect.

## Test plan
- `n_pings`=2, `rx_stb` at offsets 100 and 300 in each slot, `start` at cycle 0:
  - `tx_stb` at cycles 1 and 2049.
  - `res_valid` at cycle 4097 with `res_first`=200, `res_last`=600, `res_hits`=2, `res_miss`=0.
- `n_pings`=3, no `rx_stb` in slot 2, a single strobe at offset 50 in slots 1 and 3:
  - `res_first`=`res_last`=100, `res_hits`=2, `res_miss`=1.
- Backpressure: `res_ready` held low for 50 cycles in REPORT, with `start` pulsed meanwhile:
  - `res_*` stay stable and `busy` stays 1.
  - Accepted on `res_ready`; IDLE the next cycle; the `start` pulse is not latched.
- `abort` at offset 700 of slot 1 with `n_pings`=4:
  - No further `tx_stb`, `busy`=0 the next cycle, `res_valid` never rises.
- `rx_stb` at offsets 10 and 500, `n_pings`=1:
  - With `PING_BLANK_EN`: `res_first`=`res_last`=500.
  - Without it: `res_first`=10, `res_last`=500.
- `rst` asserted mid-LISTEN, then `start` with `n_pings`=0:
  - All outputs are 0 after reset.
  - The burst runs exactly one slot (one `tx_stb`), and `res_hits`+`res_miss`=1.
